// File: rtl/fifo_checker_pkg.sv
// Shared types and constants for the fifo_checker block.
package fifo_checker_pkg;

   typedef enum logic {
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [7:0] ERR_MAX   = 8'hFF;

endpackage

// File: rtl/fifo_checker_if.sv
// Pop handshake between a synchronous FIFO (master) and its draining stage (slave).
interface fifo_checker_if #(
   parameter int WIDTH = 8
);

   logic             is_empty;
   logic [WIDTH-1:0] data_in;
   logic             dequeue_request;

   modport master (
      output is_empty,
      output data_in,
      input  dequeue_request
   );

   modport slave (
      input  is_empty,
      input  data_in,
      output dequeue_request
   );

endinterface

// File: rtl/fifo_checker_sequence_generator.sv
// Expected-word generator: incrementing counter, or an 8-bit Galois LFSR when
// FIFO_CHECKER_LFSR_EN is defined (that build requires WIDTH = 8).
module sequence_generator
   import fifo_checker_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEED  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             advance,
   output logic [WIDTH-1:0] value
);

`ifdef FIFO_CHECKER_LFSR_EN
   // An all-zero LFSR state locks up, so a zero seed is promoted to 1.
   localparam logic [WIDTH-1:0] START = (SEED == 0) ? WIDTH'(1) : WIDTH'(SEED);

   logic [WIDTH-1:0] next_value;
   assign next_value = (value >> 1) ^ (value[0] ? WIDTH'(LFSR_TAPS) : '0);
`else
   localparam logic [WIDTH-1:0] START = WIDTH'(SEED);

   logic [WIDTH-1:0] next_value;
   assign next_value = value + WIDTH'(1);
`endif

   // NOTE: sequential state is written with <= only, so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!reset_n) value <= START;
      else if (advance) value <= next_value;
   end

endmodule

// File: rtl/fifo_checker.sv
// Drains a synchronous FIFO and checks each word against an expected sequence;
// optional LFSR sequence via FIFO_CHECKER_LFSR_EN.
module fifo_checker
   import fifo_checker_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int COUNT      = 256,
   parameter int SEED       = 0,
   parameter int SLOW       = 0,
   parameter int BLINK_BITS = 22
) (
   input  logic           clk,
   input  logic           reset_n,
   fifo_checker_if.slave  fifo,
   output logic           busy,
   output logic           done,
   output logic           good,
   output logic           bad,
   output logic [7:0]     error_count,
   output logic [7:0]     first_bad_index,
   output logic           led_g_n,
   output logic           led_r_n
);

   localparam int IDX_W = $clog2(COUNT) + 1;

   state_t                  state, state_next;
   logic [IDX_W-1:0]        index;
   logic [2:0]              delay;
   logic [2:0]              slot;
   logic [WIDTH-1:0]        expected;
   logic [BLINK_BITS-1:0]   blink_cnt;
   logic                    accept, last, mismatch, blink;

   assign slot     = 3'(index);
   assign last     = (index == IDX_W'(COUNT - 1));
   assign mismatch = (fifo.data_in != expected);

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      if (state == S_RUN) begin
         accept = reset_n && !fifo.is_empty && (SLOW == 0 || delay == slot);
         if (accept && last) state_next = S_DONE;
      end
   end

   assign fifo.dequeue_request = accept;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_RUN;
      else          state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         index           <= '0;
         delay           <= '0;
         error_count     <= '0;
         first_bad_index <= '0;
         bad             <= 1'b0;
      end else if (accept) begin
         index <= index + IDX_W'(1);
         delay <= '0;
         if (mismatch) begin
            bad <= 1'b1;
            if (error_count != ERR_MAX) error_count <= error_count + 8'd1;
            if (!bad) first_bad_index <= 8'(index);
         end
      end else if (state == S_RUN && SLOW != 0 && delay != slot) begin
         delay <= delay + 3'd1;
      end
   end

   sequence_generator #(
      .WIDTH (WIDTH),
      .SEED  (SEED)
   ) u_seq (
      .clk     (clk),
      .reset_n (reset_n),
      .advance (accept),
      .value   (expected)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) blink_cnt <= '0;
      else          blink_cnt <= blink_cnt + BLINK_BITS'(1);
   end

   assign blink   = blink_cnt[BLINK_BITS-1];
   assign busy    = (state == S_RUN);
   assign done    = (state == S_DONE);
   assign good    = done && !bad;
   // Green: heartbeat while running, solid on a clean finish, off on a failed one.
   assign led_g_n = done ? bad : !blink;
   assign led_r_n = !(bad && blink);

endmodule

// File: tb/tb_fifo_checker.sv
// Scoreboard bench for fifo_checker: a fast instance (SLOW=0) and a throttled
// instance (SLOW=1), each fed from a queue-modelled FIFO.
module tb_fifo_checker;

   localparam int CNT_A = 256;
   localparam int CNT_B = 20;
   localparam int BB    = 4;
`ifdef FIFO_CHECKER_LFSR_EN
   localparam logic [7:0] SEQ0 = 8'h01;
`else
   localparam logic [7:0] SEQ0 = 8'h00;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fifo_checker_if #(.WIDTH(8)) a_if ();
   fifo_checker_if #(.WIDTH(8)) b_if ();

   logic [1:0] busy, done, good, bad, led_g_n, led_r_n;
   logic [7:0] err   [2];
   logic [7:0] first [2];

   fifo_checker #(.WIDTH(8), .COUNT(CNT_A), .SEED(0), .SLOW(0), .BLINK_BITS(BB)) u_fast (
      .clk (clk), .reset_n (reset_n), .fifo (a_if),
      .busy (busy[0]), .done (done[0]), .good (good[0]), .bad (bad[0]),
      .error_count (err[0]), .first_bad_index (first[0]),
      .led_g_n (led_g_n[0]), .led_r_n (led_r_n[0])
   );

   fifo_checker #(.WIDTH(8), .COUNT(CNT_B), .SEED(0), .SLOW(1), .BLINK_BITS(BB)) u_slow (
      .clk (clk), .reset_n (reset_n), .fifo (b_if),
      .busy (busy[1]), .done (done[1]), .good (good[1]), .bad (bad[1]),
      .error_count (err[1]), .first_bad_index (first[1]),
      .led_g_n (led_g_n[1]), .led_r_n (led_r_n[1])
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] fqa [$];
   logic [7:0] fqb [$];
   bit         sba [$];
   bit         sbb [$];
   logic [7:0] gen [2];

   int         m_idx [2];
   int         m_err [2];
   logic [7:0] m_first [2];
   bit         m_bad [2];
   bit         m_done [2];
   logic [BB-1:0] m_blink;
   int         cyc;
   int         first_acc_a, last_acc_a;
   int         acc_cyc_b [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] nxt(input logic [7:0] e);
`ifdef FIFO_CHECKER_LFSR_EN
      return (e >> 1) ^ (e[0] ? 8'hB8 : 8'h00);
`else
      return e + 8'd1;
`endif
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         m_idx[d] = 0; m_err[d] = 0; m_first[d] = 8'h00;
         m_bad[d] = 1'b0; m_done[d] = 1'b0;
      end
      m_blink = '0;
   endtask

   task automatic model_accept(input int d, input bit mis, input int cnt);
      if (mis) begin
         if (!m_bad[d]) m_first[d] = 8'(m_idx[d]);
         m_bad[d] = 1'b1;
         if (m_err[d] < 255) m_err[d]++;
      end
      if (m_idx[d] == cnt - 1) m_done[d] = 1'b1;
      m_idx[d]++;
   endtask

   task automatic push_a(input logic [7:0] w);
      fqa.push_back(w);
      sba.push_back(w != gen[0]);
      gen[0] = nxt(gen[0]);
   endtask

   task automatic push_b(input logic [7:0] w);
      fqb.push_back(w);
      sbb.push_back(w != gen[1]);
      gen[1] = nxt(gen[1]);
   endtask

   task automatic compare(input int d);
      logic bl;
      bl = m_blink[BB-1];
      check($sformatf("busy%0d", d),  busy[d], !m_done[d]);
      check($sformatf("done%0d", d),  done[d], m_done[d]);
      check($sformatf("good%0d", d),  good[d], m_done[d] && !m_bad[d]);
      check($sformatf("bad%0d", d),   bad[d],  m_bad[d]);
      check($sformatf("errcnt%0d", d), err[d],  m_err[d]);
      check($sformatf("first%0d", d), first[d], m_first[d]);
      check($sformatf("led_g%0d", d), led_g_n[d], m_done[d] ? m_bad[d] : !bl);
      check($sformatf("led_r%0d", d), led_r_n[d], !(m_bad[d] && bl));
   endtask

   // One clock: drive FIFO heads at the falling edge, observe the pop
   // requests, let the rising edge happen, then compare against the model.
   task automatic cycle();
      logic acc0, acc1;
      bit   mis;
      a_if.is_empty = (fqa.size() == 0);
      a_if.data_in  = (fqa.size() != 0) ? fqa[0] : 8'h00;
      b_if.is_empty = (fqb.size() == 0);
      b_if.data_in  = (fqb.size() != 0) ? fqb[0] : 8'h00;
      #1;
      acc0 = a_if.dequeue_request;
      acc1 = b_if.dequeue_request;
      if (a_if.is_empty || !reset_n || m_done[0]) check("deq_idle0", acc0, 1'b0);
      if (b_if.is_empty || !reset_n || m_done[1]) check("deq_idle1", acc1, 1'b0);
      if (acc0 === 1'b1 && fqa.size() != 0) begin
         if (m_idx[0] == 0) first_acc_a = cyc;
         last_acc_a = cyc;
         void'(fqa.pop_front());
         mis = sba.pop_front();
         model_accept(0, mis, CNT_A);
      end
      if (acc1 === 1'b1 && fqb.size() != 0) begin
         acc_cyc_b.push_back(cyc);
         void'(fqb.pop_front());
         mis = sbb.pop_front();
         model_accept(1, mis, CNT_B);
      end
      @(posedge clk);
      if (!reset_n) model_clear();
      else          m_blink = m_blink + 1'b1;
      cyc++;
      @(negedge clk);
      compare(0);
      compare(1);
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      fqa.delete(); fqb.delete(); sba.delete(); sbb.delete();
      acc_cyc_b.delete();
      gen[0] = SEQ0;
      gen[1] = SEQ0;
      repeat (n) cycle();
      reset_n = 1'b1;
   endtask

   task automatic run_until_done(input int d, input int budget, input string tag);
      int n;
      n = 0;
      while (done[d] !== 1'b1 && n < budget) begin
         cycle();
         n++;
      end
      check(tag, done[d], 1'b1);
   endtask

   initial begin
      logic [7:0] w;
      int         k, n;
      cyc = 0;
      first_acc_a = 0;
      last_acc_a  = 0;
      model_clear();
      a_if.is_empty = 1'b1; a_if.data_in = 8'h00;
      b_if.is_empty = 1'b1; b_if.data_in = 8'h00;

      // Reset values, then a clean stream at full rate.
      do_reset(2);
      check("rst_err", err[0], 8'h00);
      check("rst_busy", busy[0], 1'b1);
      for (int i = 0; i < CNT_A; i++) push_a(gen[0]);
      run_until_done(0, 400, "clean_timeout");
      check("clean_span", last_acc_a - first_acc_a, CNT_A - 1);
      check("clean_good", good[0], 1'b1);
      check("clean_led_g", led_g_n[0], 1'b0);

      // Single corrupted word at index 0x37.
      do_reset(1);
      for (int i = 0; i < CNT_A; i++) begin
         w = (gen[0] == 8'h99) ? 8'h98 : 8'h99;
         push_a((i == 8'h37) ? w : gen[0]);
      end
      run_until_done(0, 400, "single_timeout");
      check("single_first", first[0], 8'h37);
      check("single_err", err[0], 8'd1);
      check("single_good", good[0], 1'b0);

      // Every word wrong: count saturates at 255.
      do_reset(1);
      for (int i = 0; i < CNT_A; i++) push_a(gen[0] ^ 8'hFF);
      run_until_done(0, 400, "sat_timeout");
      check("sat_err", err[0], 8'hFF);
      check("sat_first", first[0], 8'h00);
      check("sat_led_g", led_g_n[0], 1'b1);

      // Reset after index 100 of a dirty stream, then a clean restart.
      do_reset(1);
      for (int i = 0; i < CNT_A; i++) push_a((i == 10) ? ~gen[0] : gen[0]);
      n = 0;
      while (m_idx[0] < 101 && n < 300) begin
         cycle();
         n++;
      end
      check("midrun_reached", m_idx[0] >= 101, 1'b1);
      check("midrun_bad", bad[0], 1'b1);
      do_reset(1);
      check("midrun_cleared_err", err[0], 8'h00);
      check("midrun_cleared_bad", bad[0], 1'b0);
      for (int i = 0; i < CNT_A; i++) push_a(gen[0]);
      run_until_done(0, 400, "restart_timeout");
      check("restart_good", good[0], 1'b1);

      // Throttled instance with an intermittently empty FIFO.
      do_reset(1);
      k = 0;
      n = 0;
      while (done[1] !== 1'b1 && n < 2000) begin
         if (k < CNT_B && $urandom_range(0, 2) == 0) begin
            push_b(gen[1]);
            k++;
         end
         cycle();
         n++;
      end
      check("starve_done", done[1], 1'b1);
      check("starve_good", good[1], 1'b1);

      // Throttled instance with a full FIFO: word i costs 1 + i[2:0] cycles.
      do_reset(1);
      for (int i = 0; i < CNT_B; i++) push_b(gen[1]);
      run_until_done(1, 400, "slow_timeout");
      check("slow_accepts", acc_cyc_b.size(), CNT_B);
      if (acc_cyc_b.size() == CNT_B) begin
         for (int i = 1; i < CNT_B; i++)
            check($sformatf("slow_gap%0d", i), acc_cyc_b[i] - acc_cyc_b[i-1], 1 + (i % 8));
      end
      check("slow_good", good[1], 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_checker.md
# fifo_checker

Downstream stage of `synchronous_fifo`. Drains the FIFO with the same `dequeue_request`/`is_empty` handshake `consumer` uses, and compares each word against a locally generated expected sequence. Keeps a saturating error count and the index of the first mismatch, and reports pass/fail on two active-low LEDs. It replaces `consumer` when the test needs more than a single good/bad bit.

## Interface
Parameters:
- `WIDTH`, 8: data word width.
- `COUNT`, 256: number of words to check before finishing (≥1).
- `SEED`, 0: first expected word.
- `SLOW`, 0: when 1, insert `index[2:0]` idle cycles before each accept.
- `BLINK_BITS`, 22: width of the LED blink counter; its MSB is the blink phase.

Ports:
- `clk`, in, 1: single clock; every flop is on `posedge clk`.
- `reset_n`, in, 1: synchronous, active-low reset.
- `is_empty`, in, 1: registered empty flag from the FIFO.
- `data_in`, in, `WIDTH`: FIFO head word (`data_out` of FIFO).
- `dequeue_request`, out, 1: pop request, combinational.
- `busy`, out, 1: high while in S_RUN.
- `done`, out, 1: high in S_DONE.
- `good`, out, 1: done with zero errors.
- `bad`, out, 1: sticky, set on the first mismatch.
- `error_count`, out, 8: saturating mismatch count.
- `first_bad_index`, out, 8: word index (low 8 bits) of the first mismatch.
- `led_g_n`, out, 1: green LED, active-low.
- `led_r_n`, out, 1: red LED, active-low.

## Operation
- States: S_RUN → S_DONE.
- Reset:
  - Enter S_RUN.
  - `index`=0, `expected`=`SEED`, `delay`=0.
  - `error_count`=0, `first_bad_index`=0, `bad`=0.
  - Blink counter=0.
- S_RUN, stall phase: when `SLOW` and `delay != index[2:0]`, increment `delay`. `dequeue_request` stays 0.
- S_RUN, accept condition: `dequeue_request = !is_empty && (!SLOW || delay == index[2:0])`.
- On accept, at the next edge:
  - Compare `data_in` with `expected`.
  - On mismatch: `error_count` increments, saturating at 255. `bad` goes to 1. If this is the first mismatch, capture `first_bad_index` = `index`.
  - Advance `expected` to the next sequence value, increment `index`, clear `delay`.
  - If `index == COUNT-1`, go to S_DONE.
- S_DONE: terminal until reset. `dequeue_request` is 0 even if the FIFO is not empty.
- Expected-sequence arithmetic: the next value is `expected+1` modulo 2^`WIDTH`; 0xFF wraps to 0x00.
- `index` width is `$clog2(COUNT)+1`. Comparison is exact equality on all `WIDTH` bits.
- LEDs:
  - S_RUN: green blinks (blink MSB, heartbeat), red is off.
  - S_DONE with `good`: green solid on, red off.
  - S_DONE with `bad`: red blinks, green off.
  - `bad` asserted during S_RUN: red blinks immediately.

## Timing
- Reset values of all outputs:
  - `dequeue_request`=0 during reset. It may rise combinationally in the first cycle after `reset_n` goes high.
  - `busy`=1, `done`=0, `good`=0, `bad`=0, `error_count`=0, `first_bad_index`=0.
  - `led_g_n`=1, `led_r_n`=1.
- Handshake:
  - One word is consumed per cycle where `dequeue_request`=1; `data_in` is sampled that same cycle.
  - The FIFO's `is_empty` is registered and exact, so a request while `!is_empty` always pops.
- Latency:
  - `bad`/`error_count` update 1 cycle after the offending accept.
  - `done`/`good` assert 1 cycle after the final accept.
- Throughput:
  - `SLOW`=0: 1 word/cycle.
  - `SLOW`=1: word i costs `1 + i[2:0]` cycles.
- FIFO goes empty mid-stream: wait indefinitely, with no timeout and no state change.
- Mismatch on the final word: counted, and `good`=0.
- `error_count` at 255: holds at 255; `bad` stays 1.
- Reset mid-operation: full restart next cycle; no partial state survives.

## Configuration
- Macro `FIFO_CHECKER_LFSR_EN`.
- Defined:
  - The expected sequence is an 8-bit Galois LFSR: next = `(e >> 1) ^ (e[0] ? 8'hB8 : 8'h00)`.
  - Requires `WIDTH`=8. `SEED` must be nonzero; a zero `SEED` is replaced by 8'h01.
- Undefined: incrementing sequence, with no LFSR logic present.

## Structure
- Package `fifo_checker_pkg`:
  - State enum `{S_RUN, S_DONE}`.
  - `LFSR_TAPS` = 8'hB8.
  - `ERR_MAX` = 8'hFF.
- One sub-module, `sequence_generator`:
  - Inputs: `clk`, `reset_n`, `advance`.
  - Output: `value`.
  - Holds the counter, or the LFSR under the macro.
- The checker FSM, stall counter, error logic and LED logic stay in `fifo_checker`.

## Test plan
- Clean stream: FIFO fed 0x00..0xFF, `COUNT`=256, `SLOW`=0 → 256 accepts on consecutive cycles; `done`=`good`=1 one cycle after the last; `error_count`=0; `led_g_n`=0.
- Single error: word 0x37 replaced by 0x99 → `bad`=1 the cycle after index 55 is accepted; `first_bad_index`=0x37; `error_count`=1; `good`=0 at done.
- Saturation: all 256 words wrong → `error_count`=255 at done; `first_bad_index`=0.
- Throttle and starvation: `SLOW`=1 with an intermittently empty FIFO → word 7 accepted exactly 7 idle cycles after its stall starts; no `dequeue_request` while `is_empty`=1.
- Reset mid-run: `reset_n`=0 for 1 cycle after index 100 → counters and flags cleared; the stream restarted at 0x00 passes.
- LFSR build (`FIFO_CHECKER_LFSR_EN`, `SEED`=0x01) → expected sequence 0x01, 0xB8, 0x5C, 0x2E…; a matching 255-word stream with `COUNT`=255 gives `good`=1.
